hsi_mse_vctr_acc: RTL and testbench

- Per-vector MSE datapath directly downstream of the MSE library FSM.
- Consumes paired measure/reference words popped from the two FIFOs, framed by the FSM's element_valid/element_start/element_last strobes.
- Squares and accumulates band differences over one library vector, then emits one mean-squared-error result per vector with its library index.
- Output feeds the min-MSE comparison stage.

---
 rtl/hsi_mse_vctr_acc_if.sv | 34 +++
 rtl/hsi_mse_vctr_acc.sv | 189 ++++++++++++++++++
 tb/tb_hsi_mse_vctr_acc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hsi_mse_vctr_acc_if.sv
// Element stream from the MSE library FSM and the per-vector MSE result bus.
// The master drives paired words and framing strobes; the slave returns one result per vector.
interface hsi_mse_vctr_acc_if #(
    parameter int HSI_DATA_WIDTH        = 16,
    parameter int HSI_LIBRARY_SIZE_ADDR = 8
);
    localparam int WORD_WIDTH = 2 * HSI_DATA_WIDTH;

    logic                             element_valid;
    logic                             element_start;
    logic                             element_last;
    logic                             vctr_last;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] vctr_index;
    logic [WORD_WIDTH-1:0]            measure_word;
    logic [WORD_WIDTH-1:0]            ref_word;

    logic                             mse_valid;
    logic [2*HSI_DATA_WIDTH-1:0]      mse_value;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_index;
    logic                             mse_last;
    logic                             protocol_error;

    modport master (
        output element_valid, element_start, element_last, vctr_last,
               vctr_index, measure_word, ref_word,
        input  mse_valid, mse_value, mse_index, mse_last, protocol_error
    );

    modport slave (
        input  element_valid, element_start, element_last, vctr_last,
               vctr_index, measure_word, ref_word,
        output mse_valid, mse_value, mse_index, mse_last, protocol_error
    );
endinterface

// File: rtl/hsi_mse_vctr_acc.sv
// Per-vector mean-squared-error datapath: input capture, lane difference, lane square-sum,
// accumulate, then one registered result per library vector plus a sticky framing check.
module hsi_mse_vctr_acc #(
    parameter int HSI_DATA_WIDTH   = 16,
    parameter int HSI_BANDS        = 128,
    parameter int HSI_LIBRARY_SIZE = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    hsi_mse_vctr_acc_if.slave bus
);
    localparam int WORD_WIDTH            = 2 * HSI_DATA_WIDTH;
    localparam int ELEMENTS              = HSI_BANDS / 2;
    localparam int ELEMENTS_ADDR         = $clog2(ELEMENTS);
    localparam int CNT_W                 = (ELEMENTS_ADDR > 0) ? ELEMENTS_ADDR : 1;
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE);
    localparam int BAND_SHIFT            = $clog2(HSI_BANDS);
    localparam int ACC_WIDTH             = 2 * HSI_DATA_WIDTH + BAND_SHIFT;
    localparam int SQ_W                  = 2 * HSI_DATA_WIDTH;
    localparam int SUM_W                 = SQ_W + 1;
    localparam int PROD_W                = 2 * HSI_DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ELEMENTS - 1);

    // Framing state
    logic [CNT_W-1:0]                 r_elem_cnt;
    logic                             r_open;
    logic                             r_err;
    logic [CNT_W-1:0]                 w_cnt_cur;
    logic                             w_frame_err;

    // Stage 0: captured input word
    logic                             r_in_valid, r_in_start, r_in_last, r_in_vlast;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] r_in_index;
    logic [WORD_WIDTH-1:0]            r_in_meas, r_in_ref;

    // Stage 1: signed lane differences
    logic                             r_s1_valid, r_s1_start, r_s1_last, r_s1_vlast;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] r_s1_index;
    logic signed [HSI_DATA_WIDTH:0]   r_s1_d0, r_s1_d1;
    logic signed [HSI_DATA_WIDTH:0]   w_d0, w_d1;

    // Stage 2: lane square sum
    logic                             r_s2_valid, r_s2_start, r_s2_last, r_s2_vlast;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] r_s2_index;
    logic [SUM_W-1:0]                 r_s2_sum;
    logic signed [PROD_W-1:0]         w_p0, w_p1;
    logic [SUM_W-1:0]                 w_lane_sum;
    logic                             w_sq_unused;

    // Stage 3: accumulator
    logic                             r_s3_valid, r_s3_last, r_s3_vlast;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] r_s3_index;
    logic [ACC_WIDTH-1:0]             r_acc;

    // Output register
    logic                             r_mse_valid, r_mse_last;
    logic [SQ_W-1:0]                  r_mse_value;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] r_mse_index;

    // A start word always sits at position 0, whatever the running count says.
    assign w_cnt_cur   = bus.element_start ? {CNT_W{1'b0}} : r_elem_cnt;
    assign w_frame_err = bus.element_valid &
                         ((bus.element_start & r_open) |
                          (~bus.element_start & ~r_open) |
                          (bus.element_last & (w_cnt_cur != LAST_CNT)));

    assign w_d0 = $signed({1'b0, r_in_meas[HSI_DATA_WIDTH-1:0]}) -
                  $signed({1'b0, r_in_ref[HSI_DATA_WIDTH-1:0]});
    assign w_d1 = $signed({1'b0, r_in_meas[WORD_WIDTH-1:HSI_DATA_WIDTH]}) -
                  $signed({1'b0, r_in_ref[WORD_WIDTH-1:HSI_DATA_WIDTH]});

    // Squares never exceed (2^W-1)^2, so the two sign-extension bits are always zero.
    assign w_p0        = PROD_W'(r_s1_d0) * PROD_W'(r_s1_d0);
    assign w_p1        = PROD_W'(r_s1_d1) * PROD_W'(r_s1_d1);
    assign w_lane_sum  = SUM_W'(w_p0[SQ_W-1:0]) + SUM_W'(w_p1[SQ_W-1:0]);
    assign w_sq_unused = ^{w_p0[PROD_W-1:SQ_W], w_p1[PROD_W-1:SQ_W]};

    // Element counter, open-vector flag and sticky framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_elem_cnt <= {CNT_W{1'b0}};
            r_open     <= 1'b0;
            r_err      <= 1'b0;
        end else if (clear) begin
            r_elem_cnt <= {CNT_W{1'b0}};
            r_open     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (bus.element_valid) begin
                r_elem_cnt <= w_cnt_cur + CNT_W'(1);
                r_open     <= ~bus.element_last;
            end
            r_err <= r_err | w_frame_err;
        end
    end

    // Stage 0 and stage 1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            r_in_valid <= 1'b0;
            r_in_start <= 1'b0;
            r_in_last  <= 1'b0;
            r_in_vlast <= 1'b0;
            r_in_index <= '0;
            r_in_meas  <= '0;
            r_in_ref   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_start <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_vlast <= 1'b0;
            r_s1_index <= '0;
            r_s1_d0    <= '0;
            r_s1_d1    <= '0;
        end else begin
            r_in_valid <= bus.element_valid;
            r_in_start <= bus.element_valid & bus.element_start;
            r_in_last  <= bus.element_valid & bus.element_last;
            r_in_vlast <= bus.element_valid & bus.vctr_last;
            r_in_index <= bus.vctr_index;
            r_in_meas  <= bus.measure_word;
            r_in_ref   <= bus.ref_word;
            r_s1_valid <= r_in_valid;
            r_s1_start <= r_in_start;
            r_s1_last  <= r_in_last;
            r_s1_vlast <= r_in_vlast;
            r_s1_index <= r_in_index;
            r_s1_d0    <= w_d0;
            r_s1_d1    <= w_d1;
        end
    end

    // Stage 2 and stage 3: lane sum, then load-on-start accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            r_s2_valid <= 1'b0;
            r_s2_start <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_vlast <= 1'b0;
            r_s2_index <= '0;
            r_s2_sum   <= '0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_vlast <= 1'b0;
            r_s3_index <= '0;
            r_acc      <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_start <= r_s1_start;
            r_s2_last  <= r_s1_last;
            r_s2_vlast <= r_s1_vlast;
            r_s2_index <= r_s1_index;
            r_s2_sum   <= w_lane_sum;
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_valid & r_s2_last;
            r_s3_vlast <= r_s2_vlast;
            if (r_s2_valid && r_s2_start) begin
                r_acc      <= ACC_WIDTH'(r_s2_sum);
                r_s3_index <= r_s2_index;
            end else if (r_s2_valid) begin
                r_acc <= r_acc + ACC_WIDTH'(r_s2_sum);
            end
        end
    end

    // Result register: strobe for one cycle, hold value/index/last until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            r_mse_valid <= 1'b0;
            r_mse_value <= '0;
            r_mse_index <= '0;
            r_mse_last  <= 1'b0;
        end else if (r_s3_valid && r_s3_last) begin
            r_mse_valid <= 1'b1;
            r_mse_value <= r_acc[ACC_WIDTH-1:BAND_SHIFT];
            r_mse_index <= r_s3_index;
            r_mse_last  <= r_s3_vlast;
        end else begin
            r_mse_valid <= 1'b0;
        end
    end

    assign bus.mse_valid      = r_mse_valid;
    assign bus.mse_value      = r_mse_value;
    assign bus.mse_index      = r_mse_index;
    assign bus.mse_last       = r_mse_last;
    assign bus.protocol_error = r_err;

endmodule

// File: tb/tb_hsi_mse_vctr_acc.sv
// Randomised bench for hsi_mse_vctr_acc: expected results come from summing band
// differences squared over each sent vector, with due cycles from the fixed latency.
module tb_hsi_mse_vctr_acc;
    localparam int BANDS = 128;
    localparam int ELEM  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    hsi_mse_vctr_acc_if #(.HSI_DATA_WIDTH(16), .HSI_LIBRARY_SIZE_ADDR(8)) bus ();

    hsi_mse_vctr_acc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        longint      due;
        logic [31:0] val;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    longint      edge_cnt = 0;
    logic [15:0] m_arr[BANDS];
    logic [15:0] r_arr[BANDS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sq(input logic [15:0] a, input logic [15:0] b);
        longint d;
        d = longint'(a) - longint'(b);
        return d * d;
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard: a strobe must appear exactly on its due edge and nowhere else
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            check("mse_valid", 64'(bus.mse_valid), 64'd1);
            check("mse_value", 64'(bus.mse_value), 64'(exp_q[0].val));
            check("mse_index", 64'(bus.mse_index), 64'(exp_q[0].idx));
            check("mse_last",  64'(bus.mse_last),  64'(exp_q[0].last));
            void'(exp_q.pop_front());
        end else if (bus.mse_valid) begin
            check("spurious_strobe", 64'(bus.mse_valid), 64'd0);
        end
    end

    task automatic idle_inputs();
        bus.element_valid = 1'b0;
        bus.element_start = 1'($urandom);
        bus.element_last  = 1'($urandom);
        bus.vctr_last     = 1'($urandom);
        bus.vctr_index    = 8'($urandom);
        bus.measure_word  = $urandom;
        bus.ref_word      = $urandom;
    endtask

    task automatic send_vector(input logic [7:0] idx, input logic vl, input int nwords,
                               input logic do_last, input int bubble_pct);
        longint sum = 0;
        for (int w = 0; w < nwords; w++) begin
            while (bubble_pct > 0 && $urandom_range(99, 0) < bubble_pct) begin
                idle_inputs();
                @(posedge clk);
                #1;
            end
            bus.element_valid = 1'b1;
            bus.element_start = (w == 0);
            bus.element_last  = do_last && (w == nwords - 1);
            bus.vctr_last     = vl;
            bus.vctr_index    = (w == 0) ? idx : 8'($urandom);
            bus.measure_word  = {m_arr[2*w+1], m_arr[2*w]};
            bus.ref_word      = {r_arr[2*w+1], r_arr[2*w]};
            sum += sq(m_arr[2*w], r_arr[2*w]) + sq(m_arr[2*w+1], r_arr[2*w+1]);
            @(posedge clk);
            #1;
            if (do_last && (w == nwords - 1))
                exp_q.push_back('{due: edge_cnt + 4, val: 32'(sum >> 7), idx: idx, last: vl});
        end
        bus.element_valid = 1'b0;
        bus.element_start = 1'b0;
        bus.element_last  = 1'b0;
    endtask

    task automatic fill(input logic [15:0] me, input logic [15:0] re,
                        input logic [15:0] mo, input logic [15:0] ro);
        for (int b = 0; b < BANDS; b++) begin
            m_arr[b] = (b % 2 == 0) ? me : mo;
            r_arr[b] = (b % 2 == 0) ? re : ro;
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < BANDS; b++) begin
            m_arr[b] = 16'($urandom);
            r_arr[b] = 16'($urandom);
        end
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.mse_valid), 64'd0);
        check({tag, "_value"}, 64'(bus.mse_value), 64'd0);
        check({tag, "_index"}, 64'(bus.mse_index), 64'd0);
        check({tag, "_last"},  64'(bus.mse_last),  64'd0);
        check({tag, "_perr"},  64'(bus.protocol_error), 64'd0);
    endtask

    initial begin
        bus.element_valid = 1'b0;
        bus.element_start = 1'b0;
        bus.element_last  = 1'b0;
        bus.vctr_last     = 1'b0;
        bus.vctr_index    = 8'd0;
        bus.measure_word  = 32'd0;
        bus.ref_word      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Uniform vector: diff 3 on every band
        fill(16'd10, 16'd7, 16'd10, 16'd7);
        send_vector(8'd5, 1'b0, ELEM, 1'b1, 0);
        drain();
        check("uniform_hold_value", 64'(bus.mse_value), 64'd9);
        check("uniform_perr", 64'(bus.protocol_error), 64'd0);

        // Extremes in both operand orders
        fill(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000);
        send_vector(8'd7, 1'b0, ELEM, 1'b1, 0);
        drain();
        check("extreme_value", 64'(bus.mse_value), 64'hFFFE0001);
        fill(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF);
        send_vector(8'd8, 1'b1, ELEM, 1'b1, 0);
        drain();

        // Back-to-back vectors with no idle cycle between them
        fill(16'd100, 16'd99, 16'd100, 16'd99);
        send_vector(8'd0, 1'b0, ELEM, 1'b1, 0);
        fill(16'd50, 16'd52, 16'd50, 16'd52);
        send_vector(8'd1, 1'b1, ELEM, 1'b1, 0);
        drain();

        // Lane asymmetry with truncation, under random bubbles
        fill(16'd20, 16'd17, 16'd33, 16'd33);
        send_vector(8'd12, 1'b0, ELEM, 1'b1, 30);
        drain();
        check("asym_value", 64'(bus.mse_value), 64'd4);

        // Random vectors, mixed bubbles, back to back
        for (int v = 0; v < 6; v++) begin
            fill_random();
            send_vector(8'($urandom), 1'($urandom), ELEM, 1'b1, int'($urandom_range(40, 0)));
        end
        drain();
        check("random_perr", 64'(bus.protocol_error), 64'd0);

        // Short vector: last on word 10 flags an error but still yields a result
        fill_random();
        send_vector(8'd20, 1'b0, 11, 1'b1, 0);
        drain();
        check("short_perr", 64'(bus.protocol_error), 64'd1);

        // clear while a result is in flight: error cleared, strobe dropped
        fill_random();
        send_vector(8'd9, 1'b0, ELEM, 1'b1, 0);
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].due > edge_cnt)
            void'(exp_q.pop_back());
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_perr", 64'(bus.protocol_error), 64'd0);
        check("clear_valid", 64'(bus.mse_valid), 64'd0);
        repeat (10) @(posedge clk);
        #1;

        // Reset in the middle of a vector, then a full vector
        fill(16'd10, 16'd7, 16'd10, 16'd7);
        send_vector(8'd3, 1'b0, 30, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_random();
        send_vector(8'd4, 1'b1, ELEM, 1'b1, 10);
        drain();
        check("final_perr", 64'(bus.protocol_error), 64'd0);
        check("pending_results", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
